// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: iterative multiply/divide sequencer that owns HI/LO.
// A 4-bit busy countdown models the iteration latency. Completed results are
// written to HI/LO at the last busy edge. stall_md holds a D-stage HI/LO user
// while an operation is in flight or is starting this cycle.
// Optional feature: define MULDIV_MADD_EN to enable MADD/MADDU (op 6/7),
// which accumulate their product into {hi,lo}. Otherwise op 6/7 are no-ops.
module muldiv_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        md_use_d,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        stall_md
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
`ifdef MULDIV_MADD_EN
    localparam logic [2:0] OP_MADD  = 3'd6;
    localparam logic [2:0] OP_MADDU = 3'd7;
`endif

    typedef enum logic {
        IDLE,
        BUSY
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [2:0]  op_q;
    logic [31:0] a_q;
    logic [31:0] b_q;

    logic        long_op;
    logic        is_div;

    logic signed [63:0] sa64;
    logic signed [63:0] sb64;
    logic signed [63:0] prod_s;
    logic [63:0]        prod_u;
    logic signed [31:0] sa32;
    logic signed [31:0] sb32;
    logic signed [31:0] q_s;
    logic signed [31:0] r_s;
    logic [63:0]        res;

    // Decode which ops occupy the iterative unit
    always_comb begin
`ifdef MULDIV_MADD_EN
        long_op = start & ((op <= OP_DIVU) | (op == OP_MADD) | (op == OP_MADDU));
`else
        long_op = start & (op <= OP_DIVU);
`endif
        is_div = (op == OP_DIV) | (op == OP_DIVU);
    end

    assign stall_md = md_use_d & (busy | long_op);

    // Result of the latched operation, consumed at the completing edge
    always_comb begin
        sa64   = {{32{a_q[31]}}, a_q};
        sb64   = {{32{b_q[31]}}, b_q};
        prod_s = sa64 * sb64;
        prod_u = {32'b0, a_q} * {32'b0, b_q};
        sa32   = a_q;
        sb32   = b_q;
        q_s    = '0;
        r_s    = '0;
        res    = {hi, lo};
        case (op_q)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV: begin
                if (b_q == '0) begin
                    res = {a_q, 32'hFFFF_FFFF};
                end else if (a_q == 32'h8000_0000 && b_q == '1) begin
                    // Only signed quotient that overflows 32 bits; pinned explicitly
                    res = {32'h0, 32'h8000_0000};
                end else begin
                    q_s = sa32 / sb32;
                    r_s = sa32 % sb32;
                    res = {r_s, q_s};
                end
            end
            OP_DIVU: begin
                if (b_q == '0) begin
                    res = {a_q, 32'hFFFF_FFFF};
                end else begin
                    res = {a_q % b_q, a_q / b_q};
                end
            end
`ifdef MULDIV_MADD_EN
            OP_MADD:  res = {hi, lo} + prod_s;
            OP_MADDU: res = {hi, lo} + prod_u;
`endif
            default:  res = {hi, lo};
        endcase
    end

    // Sequencer: launch, count down, retire into HI/LO; MTHI/MTLO write directly
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (long_op) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        cnt   <= is_div ? 4'(DIV_CYCLES - 1) : 4'(MULT_CYCLES - 1);
                        busy  <= 1'b1;
                        state <= BUSY;
                    end else if (start && op == OP_MTHI) begin
                        hi <= a;
                    end else if (start && op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        hi    <= res[63:32];
                        lo    <= res[31:0];
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: directed vectors, a cycle-level arithmetic model
// compared every cycle, and literal expectations for the documented cases.
module tb_muldiv_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    localparam logic [2:0] MULT  = 3'd0;
    localparam logic [2:0] MULTU = 3'd1;
    localparam logic [2:0] DIV   = 3'd2;
    localparam logic [2:0] DIVU  = 3'd3;
    localparam logic [2:0] MTHI  = 3'd4;
    localparam logic [2:0] MTLO  = 3'd5;
    localparam logic [2:0] MADD  = 3'd6;
    localparam logic [2:0] MADDU = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  op = '0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        md_use_d = 1'b0;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        stall_md;

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    // Model state: expected registers and busy cycles still to run
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;
    int          m_left = 0;
    logic [2:0]  m_op = '0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;

    muldiv_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .md_use_d(md_use_d), .busy(busy), .hi(hi), .lo(lo), .stall_md(stall_md)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit occupies(input logic [2:0] o);
`ifdef MULDIV_MADD_EN
        return (o <= DIVU) || (o == MADD) || (o == MADDU);
`else
        return o <= DIVU;
`endif
    endfunction

    function automatic logic [63:0] arith(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y, input logic [63:0] acc);
        longint sx, sy, q, r;
        logic [63:0] ux, uy, uq, ur;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (o)
            MULT:  return sx * sy;
            MULTU: return ux * uy;
            DIV: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            DIVU: begin
                if (y == 0) return {x, 32'hFFFF_FFFF};
                uq = ux / uy;
                ur = ux % uy;
                return {ur[31:0], uq[31:0]};
            end
            MADD:  return acc + (sx * sy);
            default: return acc + (ux * uy);
        endcase
    endfunction

    // Reference model advanced on the same edge the DUT samples
    always @(posedge clk) begin
        logic [63:0] r;
        if (reset) begin
            m_hi = '0;
            m_lo = '0;
            m_left = 0;
        end else if (m_left > 0) begin
            if (start) begin
                miscompares++;
                vectors++;
                $display("FAIL protocol: start while busy at %0t", $time);
            end
            m_left--;
            if (m_left == 0) begin
                r = arith(m_op, m_a, m_b, {m_hi, m_lo});
                m_hi = r[63:32];
                m_lo = r[31:0];
            end
        end else if (start) begin
            if (occupies(op)) begin
                m_op = op;
                m_a = a;
                m_b = b;
                m_left = (op == DIV || op == DIVU) ? DC : MC;
            end else if (op == MTHI) begin
                m_hi = a;
            end else if (op == MTLO) begin
                m_lo = a;
            end
        end
    end

    // Compare DUT to model mid-cycle, every cycle after the first reset edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'b0, busy}, {31'b0, m_left > 0});
            chk("hi", hi, m_hi);
            chk("lo", lo, m_lo);
            chk("stall_md", {31'b0, stall_md},
                {31'b0, md_use_d & ((m_left > 0) | (start & occupies(op)))});
        end
    end

    // Issue one op for a single cycle and wait for busy to drop; returns busy cycles
    task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic md, output int ncyc);
        @(posedge clk); #2;
        start = 1'b1; op = o; a = x; b = y; md_use_d = md;
        #1;
        if (md) chk("stall_start", {31'b0, stall_md}, {31'b0, occupies(o)});
        @(posedge clk); #2;
        start = 1'b0;
        ncyc = 0;
        while (busy && ncyc < 40) begin
            ncyc++;
            @(posedge clk); #2;
        end
        if (ncyc >= 40) chk("busy_timeout", 32'(ncyc), 32'd0);
    endtask

    initial begin
        int n;
        @(posedge clk); #2;
        chk_en = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);

        // MULT -2 * 3
        do_op(MULT, 32'hFFFF_FFFE, 32'd3, 1'b0, n);
        chk("mult_cycles", 32'(n), 32'd5);
        chk("mult_hi", hi, 32'hFFFF_FFFF);
        chk("mult_lo", lo, 32'hFFFF_FFFA);

        // MULTU all-ones squared
        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, n);
        chk("multu_hi", hi, 32'hFFFF_FFFE);
        chk("multu_lo", lo, 32'h0000_0001);

        // DIVU 100 / 7
        do_op(DIVU, 32'd100, 32'd7, 1'b0, n);
        chk("divu_cycles", 32'(n), 32'd10);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        // DIV -7 / 2
        do_op(DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, n);
        chk("div_lo", lo, 32'hFFFF_FFFD);
        chk("div_hi", hi, 32'hFFFF_FFFF);

        // Divide by zero
        do_op(DIV, 32'd5, 32'd0, 1'b0, n);
        chk("div0_cycles", 32'(n), 32'd10);
        chk("div0_hi", hi, 32'd5);
        chk("div0_lo", lo, 32'hFFFF_FFFF);

        // Signed overflow case
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, n);
        chk("divovf_lo", lo, 32'h8000_0000);
        chk("divovf_hi", hi, 32'h0);

        // Stall window with a D-stage mflo present each cycle
        do_op(MULT, 32'd7, 32'd9, 1'b1, n);
        #3;
        chk("stall_after", {31'b0, stall_md}, 32'd0);
        md_use_d = 1'b0;
        chk("mult79_lo", lo, 32'd63);
        do_op(MULT, 32'd3, 32'd4, 1'b0, n);

        // Reset in the third busy cycle of a DIV aborts it
        @(posedge clk); #2;
        start = 1'b1; op = DIV; a = 32'd1000; b = 32'd3;
        @(posedge clk); #2;
        start = 1'b0;
        @(posedge clk); #2;
        @(posedge clk); #2;
        chk("abort_busy_pre", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);

        // MTLO / MTHI write without busy
        do_op(MTLO, 32'h1234, 32'd0, 1'b0, n);
        chk("mtlo_cycles", 32'(n), 32'd0);
        chk("mtlo_lo", lo, 32'h1234);
        do_op(MTHI, 32'h0, 32'd0, 1'b0, n);
        do_op(MTLO, 32'hFFFF_FFFF, 32'd0, 1'b0, n);
        chk("mthi_hi", hi, 32'h0);

        // MADDU 1*1 onto {0, FFFF_FFFF}
        do_op(MADDU, 32'd1, 32'd1, 1'b1, n);
        md_use_d = 1'b0;
`ifdef MULDIV_MADD_EN
        chk("maddu_cycles", 32'(n), 32'd5);
        chk("maddu_hi", hi, 32'd1);
        chk("maddu_lo", lo, 32'd0);
        do_op(MADD, 32'hFFFF_FFFF, 32'd1, 1'b0, n);
        chk("madd_hi", hi, 32'd0);
        chk("madd_lo", lo, 32'hFFFF_FFFF);
`else
        chk("maddu_cycles", 32'(n), 32'd0);
        chk("maddu_hi", hi, 32'd0);
        chk("maddu_lo", lo, 32'hFFFF_FFFF);
        do_op(MADD, 32'hFFFF_FFFF, 32'd1, 1'b0, n);
        chk("madd_busy", {31'b0, busy}, 32'd0);
        chk("madd_lo", lo, 32'hFFFF_FFFF);
`endif

        @(posedge clk); #2;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
